edge_detect_array: RTL and testbench
====================================

// Module: edge_detect_array
// PURPOSE
//  Multi-channel, parametrised edge detector. Generalises single-bit falling-edge flagging.
//  Per channel: N-stage input synchroniser, then a programmable glitch filter, then a
//    runtime-selectable rising/falling/both edge detector, then a sticky flag.
//  Used at async status/trigger inputs of the testbed FPGA ahead of control FSMs and CSRs.
// PARAMETERS
//  CH          8   number of independent channels
//  SYNC_STAGES 2   synchroniser flops per channel (>=2)
//  FILT_W      4   width of glitch-filter length/counter
//  CNT_W       16  width of per-channel edge counter (EDGE_CNT_EN only)
// PORTS
//  I_clk        in   1          single clock; all logic on posedge
//  I_rstN       in   1          asynchronous, active-low reset
//  I_sig        in   CH         raw asynchronous inputs
//  I_mode       in   2          00 off, 01 rising, 10 falling, 11 both
//  I_filtLen    in   FILT_W     glitch-filter length; 0 = bypass
//  I_clrSticky  in   1          1-cycle pulse; clears all O_sticky bits
//  O_edgePulse  out  CH         1-cycle pulse per detected edge
//  O_edgeRise   out  CH         qualifies O_edgePulse: 1 = rising, 0 = falling
//  O_sticky     out  CH         latched "edge seen" flags
//  O_anyEdge    out  1          registered OR of O_edgePulse
// BEHAVIOUR
//  Reset (async assert, sync release): sync chain, filter state, counters, all outputs = 0.
//  Priming: after reset release, a PRIME counter runs SYNC_STAGES+1 cycles.
//    During priming, filter state S loads the sync output directly. No pulses.
//    So a line high at release yields no spurious rising edge.
//  Filter, per channel, sync output Y vs stable state S:
//    - Y!=S: cnt++. When cnt==I_filtLen, S<=Y and cnt<=0.
//    - Y==S: cnt<=0.
//    - I_filtLen=0: S<=Y every cycle.
//    - If I_filtLen is lowered below the current cnt, treat it as cnt>=I_filtLen: update next cycle.
//  Detect: rise = S_new & ~S_old; fall = ~S_new & S_old.
//    O_edgePulse = (rise & mode[0]) | (fall & mode[1]), registered.
//    O_edgeRise = rise, registered.
//  Latency: an input change sampled at clock edge k gives a pulse at edge k+SYNC_STAGES+1+I_filtLen.
//    The input must be held through the filter window.
//    A glitch shorter than I_filtLen+1 cycles at Y produces no pulse and no S change.
//  I_mode change: takes effect the next cycle. It never itself produces a pulse.
//    Mode 00 suppresses pulses only; S still tracks Y.
//  Sticky: set on O_edgePulse. Cleared by I_clrSticky.
//    Set and clear in the same cycle: set wins (bit stays 1).
//  O_anyEdge: 1 cycle after any O_edgePulse bit; same latency class, registered.
//  Channels are fully independent. Simultaneous edges on all CH all pulse in the same cycle.
//  Reset mid-filter or mid-pulse: everything returns to reset values and priming restarts.
// CONFIGURATION
//  EDGE_CNT_EN defined: adds ports
//    I_clrCnt  in   1         1-cycle pulse; zeroes all counters
//    O_edgeCnt out  CH*CNT_W  per-channel edge count; channel c at [c*CNT_W +: CNT_W]
//    - Counter increments on each O_edgePulse bit and saturates at 2^CNT_W-1 (no wrap).
//    - I_clrCnt and a pulse in the same cycle: result = 1 (the clear is applied, then the count).
//    - Reset value 0.
//  EDGE_CNT_EN undefined: those ports and the counters do not exist. All other behaviour is identical.
// TESTING
//  1 Reset release with I_sig=8'hFF, mode 11, filtLen 0.
//    -> No O_edgePulse for 20 cycles; O_sticky=0.
//  2 CH0 0->1 at edge k, SYNC_STAGES=2, filtLen 0, mode 01.
//    -> O_edgePulse[0]=1 only at edge k+3; O_edgeRise[0]=1; O_anyEdge=1 at k+4.
//  3 filtLen 3: 3-cycle glitch on CH1 -> no pulse. 4-cycle hold -> pulse at k+6.
//  4 Mode 10, CH2 toggles 1->0->1.
//    -> Only the falling edge pulses, with O_edgeRise[2]=0.
//    -> Switch to mode 00 mid-stream: no pulses.
//  5 I_clrSticky in the same cycle as CH3 pulse -> O_sticky[3] stays 1.
//    Clear alone next cycle -> 0.
//  6 EDGE_CNT_EN, CNT_W=4, 20 edges on CH0.
//    -> O_edgeCnt[3:0]=15, held.
//    -> I_clrCnt plus a coincident edge -> 1.
//  Also: assert I_rstN low mid-filter -> all outputs 0 immediately.

Source files
------------

// File: rtl/edge_detect_array_if.sv
// Bundles the data-side signals of edge_detect_array; clock and reset stay plain ports.
// The EDGE_CNT_EN macro adds the counter clear input and the packed per-channel counts.
interface edge_detect_array_if #(
    parameter int CH     = 8,
    parameter int FILT_W = 4
`ifdef EDGE_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    logic [CH-1:0]     I_sig;
    logic [1:0]        I_mode;
    logic [FILT_W-1:0] I_filtLen;
    logic              I_clrSticky;
    logic [CH-1:0]     O_edgePulse;
    logic [CH-1:0]     O_edgeRise;
    logic [CH-1:0]     O_sticky;
    logic              O_anyEdge;

`ifdef EDGE_CNT_EN
    logic                I_clrCnt;
    logic [CH*CNT_W-1:0] O_edgeCnt;

    modport master (
        output I_sig, I_mode, I_filtLen, I_clrSticky, I_clrCnt,
        input  O_edgePulse, O_edgeRise, O_sticky, O_anyEdge, O_edgeCnt
    );

    modport slave (
        input  I_sig, I_mode, I_filtLen, I_clrSticky, I_clrCnt,
        output O_edgePulse, O_edgeRise, O_sticky, O_anyEdge, O_edgeCnt
    );
`else
    modport master (
        output I_sig, I_mode, I_filtLen, I_clrSticky,
        input  O_edgePulse, O_edgeRise, O_sticky, O_anyEdge
    );

    modport slave (
        input  I_sig, I_mode, I_filtLen, I_clrSticky,
        output O_edgePulse, O_edgeRise, O_sticky, O_anyEdge
    );
`endif
endinterface

// File: rtl/edge_detect_array.sv
// Multi-channel synchronise / glitch-filter / edge-detect / sticky-flag block.
// Defining EDGE_CNT_EN adds saturating per-channel edge counters.
module edge_detect_array #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
`ifdef EDGE_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic               I_clk,
    input  logic               I_rstN,
    edge_detect_array_if.slave bus
);

    localparam int PRIME_N = SYNC_STAGES + 1;
    localparam int PW      = $clog2(PRIME_N + 1);

    typedef enum logic [0:0] {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [PW-1:0]     r_prime;
    logic [PW-1:0]     w_primeNext;
    logic              w_priming;

    logic [CH-1:0]     r_sync [SYNC_STAGES];
    logic [CH-1:0]     w_y;

    logic [CH-1:0]     r_s;
    logic [CH-1:0]     r_sOld;
    logic [CH-1:0]     w_sNext;
    logic [FILT_W-1:0] r_fcnt     [CH];
    logic [FILT_W-1:0] w_fcntNext [CH];

    logic [CH-1:0]     w_rise;
    logic [CH-1:0]     w_fall;
    logic [CH-1:0]     r_pulse;
    logic [CH-1:0]     r_rise;
    logic [CH-1:0]     r_sticky;
    logic              r_any;

    always_ff @(posedge I_clk or negedge I_rstN) begin
        if (!I_rstN) begin
            r_state <= ST_PRIME;
            r_prime <= '0;
        end else begin
            r_state <= w_stateNext;
            r_prime <= w_primeNext;
        end
    end

    // Priming lasts long enough for the synchroniser to fill before S is trusted.
    always_comb begin
        w_stateNext = r_state;
        w_primeNext = r_prime;
        w_priming   = 1'b0;
        case (r_state)
            ST_PRIME: begin
                w_priming   = 1'b1;
                w_primeNext = r_prime + 1'b1;
                if (r_prime == PW'(PRIME_N - 1)) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                w_stateNext = ST_RUN;
            end
            default: begin
                w_stateNext = ST_PRIME;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rstN) begin
        if (!I_rstN) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= bus.I_sig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_y = r_sync[SYNC_STAGES-1];

    // Using >= rather than == lets a length lowered mid-count still complete.
    always_comb begin
        w_sNext = r_s;
        for (int c = 0; c < CH; c++) begin
            w_fcntNext[c] = '0;
            if (w_priming) begin
                w_sNext[c] = w_y[c];
            end else if (w_y[c] != r_s[c]) begin
                if (r_fcnt[c] >= bus.I_filtLen) begin
                    w_sNext[c] = w_y[c];
                end else begin
                    w_fcntNext[c] = r_fcnt[c] + 1'b1;
                end
            end
        end
    end

    // r_sOld tracks Y during priming so the first running cycle sees no edge.
    always_ff @(posedge I_clk or negedge I_rstN) begin
        if (!I_rstN) begin
            r_s    <= '0;
            r_sOld <= '0;
            for (int c = 0; c < CH; c++) begin
                r_fcnt[c] <= '0;
            end
        end else begin
            r_s    <= w_sNext;
            r_sOld <= w_priming ? w_y : r_s;
            for (int c = 0; c < CH; c++) begin
                r_fcnt[c] <= w_fcntNext[c];
            end
        end
    end

    assign w_rise = r_s & ~r_sOld;
    assign w_fall = ~r_s & r_sOld;

    always_ff @(posedge I_clk or negedge I_rstN) begin
        if (!I_rstN) begin
            r_pulse  <= '0;
            r_rise   <= '0;
            r_sticky <= '0;
            r_any    <= 1'b0;
        end else begin
            r_pulse  <= w_priming ? '0 :
                        ((w_rise & {CH{bus.I_mode[0]}}) | (w_fall & {CH{bus.I_mode[1]}}));
            r_rise   <= w_priming ? '0 : w_rise;
            r_sticky <= (r_sticky & ~{CH{bus.I_clrSticky}}) | r_pulse;
            r_any    <= |r_pulse;
        end
    end

    assign bus.O_edgePulse = r_pulse;
    assign bus.O_edgeRise  = r_rise;
    assign bus.O_sticky    = r_sticky;
    assign bus.O_anyEdge   = r_any;

`ifdef EDGE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_edgeCnt [CH];

    // A clear coinciding with a pulse leaves that pulse counted.
    always_ff @(posedge I_clk or negedge I_rstN) begin
        if (!I_rstN) begin
            for (int c = 0; c < CH; c++) begin
                r_edgeCnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (bus.I_clrCnt) begin
                    r_edgeCnt[c] <= CNT_W'(r_pulse[c]);
                end else if (r_pulse[c] && (r_edgeCnt[c] != CNT_MAX)) begin
                    r_edgeCnt[c] <= r_edgeCnt[c] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cntOut
        assign bus.O_edgeCnt[g*CNT_W +: CNT_W] = r_edgeCnt[g];
    end
`endif

endmodule

// File: tb/tb_edge_detect_array.sv
// Bench for edge_detect_array: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_edge_detect_array;

    localparam int CH     = 8;
    localparam int SYNC   = 2;
    localparam int FILT_W = 4;
`ifdef EDGE_CNT_EN
    localparam int CNT_W  = 4;
`endif

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    edge_detect_array_if #(
        .CH(CH),
        .FILT_W(FILT_W)
`ifdef EDGE_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) bus ();

    edge_detect_array #(
        .CH(CH),
        .SYNC_STAGES(SYNC),
        .FILT_W(FILT_W)
`ifdef EDGE_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .I_clk (clk),
        .I_rstN(rstN),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] sig, input logic [1:0] mode, input logic [FILT_W-1:0] fl);
        bus.I_sig     = sig;
        bus.I_mode    = mode;
        bus.I_filtLen = fl;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: Y is the input delayed SYNC edges; S flips once Y has
    // disagreed with it for filtLen+1 consecutive edges; an edge seen at one edge
    // appears on the outputs after the next one, gated by the mode at that time.
    logic [CH-1:0] mDelay [SYNC];
    int            mRun   [CH];
    int            mCnt   [CH];
    logic [CH-1:0] mS, mEvRise, mEvFall, mPulse, mRise, mSticky;
    logic          mAny;
    int            edgeN;

    task automatic modelReset();
        for (int j = 0; j < SYNC; j++) mDelay[j] = '0;
        for (int c = 0; c < CH; c++) begin
            mRun[c] = 0;
            mCnt[c] = 0;
        end
        mS = '0; mEvRise = '0; mEvFall = '0;
        mPulse = '0; mRise = '0; mSticky = '0; mAny = 1'b0;
        edgeN = 0;
    endtask

    task automatic modelStep();
        logic [CH-1:0] y, prevPulse, newS;
        y = mDelay[0];
        for (int j = 0; j < SYNC - 1; j++) mDelay[j] = mDelay[j+1];
        mDelay[SYNC-1] = bus.I_sig;
        prevPulse = mPulse;
        if (edgeN < SYNC + 1) begin
            mS = y;
            for (int c = 0; c < CH; c++) mRun[c] = 0;
            mEvRise = '0; mEvFall = '0; mPulse = '0; mRise = '0;
        end else begin
            mPulse = (mEvRise & {CH{bus.I_mode[0]}}) | (mEvFall & {CH{bus.I_mode[1]}});
            mRise  = mEvRise;
            newS   = mS;
            for (int c = 0; c < CH; c++) begin
                if (y[c] != mS[c]) begin
                    mRun[c]++;
                    if (mRun[c] >= int'(bus.I_filtLen) + 1) begin
                        newS[c] = y[c];
                        mRun[c] = 0;
                    end
                end else begin
                    mRun[c] = 0;
                end
            end
            mEvRise = newS & ~mS;
            mEvFall = ~newS & mS;
            mS      = newS;
        end
        mSticky = (mSticky & ~{CH{bus.I_clrSticky}}) | prevPulse;
        mAny    = |prevPulse;
`ifdef EDGE_CNT_EN
        for (int c = 0; c < CH; c++) begin
            if (bus.I_clrCnt) mCnt[c] = prevPulse[c] ? 1 : 0;
            else if (prevPulse[c] && mCnt[c] < (1 << CNT_W) - 1) mCnt[c]++;
        end
`endif
        if (edgeN < 1000) edgeN++;
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) modelReset();
        else       modelStep();
    end

    always @(negedge clk) begin
        checkOutput("model_pulse",  64'(bus.O_edgePulse), 64'(mPulse));
        checkOutput("model_rise",   64'(bus.O_edgeRise),  64'(mRise));
        checkOutput("model_sticky", 64'(bus.O_sticky),    64'(mSticky));
        checkOutput("model_any",    64'(bus.O_anyEdge),   64'(mAny));
`ifdef EDGE_CNT_EN
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("model_cnt%0d", c),
                        64'(bus.O_edgeCnt[c*CNT_W +: CNT_W]), 64'(mCnt[c]));
        end
`endif
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CH-1:0] mask;
        applyStimulus(8'hFF, 2'b11, 4'd0);
        bus.I_clrSticky = 1'b0;
`ifdef EDGE_CNT_EN
        bus.I_clrCnt = 1'b0;
`endif
        rstN = 1'b0;
        waitCycles(3);
        checkOutput("reset_pulse",  64'(bus.O_edgePulse), 64'(8'h00));
        checkOutput("reset_sticky", 64'(bus.O_sticky),    64'(8'h00));
        checkOutput("reset_any",    64'(bus.O_anyEdge),   64'(1'b0));
        rstN = 1'b1;

        // Line already high at release must not look like a rising edge.
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checkOutput("t1_noPulse", 64'(bus.O_edgePulse), 64'(8'h00));
        end
        checkOutput("t1_sticky", 64'(bus.O_sticky), 64'(8'h00));

        applyStimulus(8'h00, 2'b01, 4'd0);
        waitCycles(6);
        bus.I_sig[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("t2_pulse", 64'(bus.O_edgePulse), 64'((i == 4) ? 8'h01 : 8'h00));
            checkOutput("t2_any",   64'(bus.O_anyEdge),   64'(i == 5));
            if (i == 4) checkOutput("t2_rise0", 64'(bus.O_edgeRise[0]), 64'(1'b1));
        end

        applyStimulus(8'h01, 2'b01, 4'd3);
        waitCycles(2);
        bus.I_sig[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) bus.I_sig[1] = 1'b0;
            checkOutput("t3_glitch", 64'(bus.O_edgePulse), 64'(8'h00));
        end
        bus.I_sig[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 4) bus.I_sig[1] = 1'b0;
            checkOutput("t3_hold", 64'(bus.O_edgePulse), 64'((i == 7) ? 8'h02 : 8'h00));
        end
        waitCycles(8);

        applyStimulus(8'h05, 2'b10, 4'd0);
        waitCycles(6);
        bus.I_sig[2] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("t4_fall", 64'(bus.O_edgePulse), 64'((i == 4) ? 8'h04 : 8'h00));
            if (i == 4) checkOutput("t4_rise2", 64'(bus.O_edgeRise[2]), 64'(1'b0));
        end
        bus.I_sig[2] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("t4_riseMasked", 64'(bus.O_edgePulse), 64'(8'h00));
        end
        bus.I_sig[2] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) bus.I_mode = 2'b00;
            if (i == 6) bus.I_sig[2] = 1'b1;
            checkOutput("t4_modeOff", 64'(bus.O_edgePulse), 64'(8'h00));
        end

        bus.I_mode = 2'b11;
        waitCycles(1);
        bus.I_sig[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checkOutput("t5_pulse3", 64'(bus.O_edgePulse[3]), 64'(1'b1));
                bus.I_clrSticky = 1'b1;
            end
            if (i == 5) checkOutput("t5_stickySet", 64'(bus.O_sticky[3]), 64'(1'b1));
            if (i == 6) begin
                checkOutput("t5_stickyClr", 64'(bus.O_sticky[3]), 64'(1'b0));
                bus.I_clrSticky = 1'b0;
            end
        end

`ifdef EDGE_CNT_EN
        bus.I_clrCnt = 1'b1;
        waitCycles(1);
        bus.I_clrCnt = 1'b0;
        for (int t = 0; t < 20; t++) begin
            bus.I_sig[0] = ~bus.I_sig[0];
            waitCycles(4);
        end
        waitCycles(4);
        checkOutput("t6_sat",  64'(bus.O_edgeCnt[CNT_W-1:0]), 64'(15));
        waitCycles(5);
        checkOutput("t6_hold", 64'(bus.O_edgeCnt[CNT_W-1:0]), 64'(15));
        bus.I_sig[0] = ~bus.I_sig[0];
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) bus.I_clrCnt = 1'b1;
            if (i == 5) begin
                checkOutput("t6_clrPlusEdge", 64'(bus.O_edgeCnt[CNT_W-1:0]), 64'(1));
                bus.I_clrCnt = 1'b0;
            end
        end
`endif

        bus.I_sig[5] = 1'b1;
        waitCycles(6);
        checkOutput("rst_stickyPre", 64'(bus.O_sticky[5]), 64'(1'b1));
        bus.I_filtLen = 4'd5;
        bus.I_sig[4]  = 1'b1;
        waitCycles(3);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_pulse",  64'(bus.O_edgePulse), 64'(8'h00));
        checkOutput("rst_rise",   64'(bus.O_edgeRise),  64'(8'h00));
        checkOutput("rst_sticky", 64'(bus.O_sticky),    64'(8'h00));
        checkOutput("rst_any",    64'(bus.O_anyEdge),   64'(1'b0));
`ifdef EDGE_CNT_EN
        checkOutput("rst_cnt", 64'(bus.O_edgeCnt), 64'(0));
`endif
        waitCycles(2);
        rstN = 1'b1;

        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (n == 1200) begin
                #2 rstN = 1'b0;
            end else if (n == 1203) begin
                rstN = 1'b1;
            end
            for (int c = 0; c < CH; c++) mask[c] = ($urandom_range(0, 11) == 0);
            bus.I_sig = bus.I_sig ^ mask;
            if ($urandom_range(0, 40) == 0) bus.I_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) bus.I_filtLen = FILT_W'($urandom_range(0, 5));
            bus.I_clrSticky = ($urandom_range(0, 9) == 0);
`ifdef EDGE_CNT_EN
            bus.I_clrCnt = ($urandom_range(0, 49) == 0);
`endif
        end
        bus.I_clrSticky = 1'b0;
`ifdef EDGE_CNT_EN
        bus.I_clrCnt = 1'b0;
`endif
        waitCycles(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
